ordered_rw_arbiter: RTL and testbench
=====================================

Name: ordered_rw_arbiter

Overview:
- Issue-order reader/writer arbiter that shares one execution condition register between NUM_PORTS pipeline requesters.
- Readers share access. A writer gets exclusive access.
- Age is taken from each requester's issue id, with wrap-around ordering, so an older writer blocks younger readers and cannot starve.
- Sits in front of the condition register. Its grant vector gates register writes and tells readers the value is stable.

Parameters:
NUM_PORTS, 4, number of requester ports (>=2)
ID_WIDTH, 4, issue-id width; ordering is modulo 2^ID_WIDTH

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_read  input  1 x NUM_PORTS  read (shared) request, held until release
req_write  input  1 x NUM_PORTS  write (exclusive) request, held until release; wins if req_read also high
req_issue_id  input  ID_WIDTH x NUM_PORTS  issue id of each port's request, stable while requesting
release_lock  input  1 x NUM_PORTS  one-cycle pulse, holder gives up access
grant  output  1 x NUM_PORTS  registered; high while port holds the lock
lock_busy  output  1  registered; high when any holder exists
writer_active  output  1  registered; high in EXCLUSIVE
holder_count  output  $clog2(NUM_PORTS+1)  registered number of current holders

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at posedge clk.
- Reset values: grant all 0, lock_busy 0, writer_active 0, holder_count 0, state IDLE. Reset mid-operation drops all holders in that edge, with no release needed.
- Pending port: req_read or req_write high, grant low, and release_lock low that cycle.
- Age rule: id a is older than id b iff bit ID_WIDTH-1 of (a - b) mod 2^ID_WIDTH is 1. Equal ids are broken by lower port index.
- Latency: a grant decided in cycle N is visible at N+1. A release sampled in cycle N clears that grant at N+1.
- Same-cycle handoff: releases in cycle N are applied before arbitration in cycle N, so a waiting port can be granted at N+1.
- Release re-arbitration: a port releasing in cycle N is not eligible in cycle N. If its request stays high, it competes again from N+1.
- Release from a non-holder is ignored. A pending request that drops before grant is withdrawn with no effect.
- Held grant stays high until release_lock, even if the request is deasserted.
- State IDLE: find the oldest pending port P.
  - P is a writer: grant only P, go to EXCLUSIVE.
  - P is a reader: grant every pending reader older than the oldest pending writer (all pending readers if no writer is pending), go to SHARED.
- State SHARED: each cycle, grant any pending reader that is older than every pending writer. Pending writers wait.
  - When the holder set becomes empty after releases, arbitrate as IDLE in the same cycle.
  - If no request is pending at that point, go to IDLE.
- State EXCLUSIVE: no new grants.
  - On writer release, arbitrate as IDLE in the same cycle, so the next state is SHARED, EXCLUSIVE or IDLE.
- Invariants, checked by assertion:
  - At most one writer holder.
  - Never a writer and a reader holder together.
  - holder_count equals popcount(grant).
  - lock_busy equals holder_count != 0.
  - writer_active equals state EXCLUSIVE.
- Wrap-around: with ID_WIDTH=4, id 1 is older than 15 is false; 15 is older than 1 is true.

Test Plan:
- Reset, no requests for 5 cycles -> grant 0000, lock_busy 0, holder_count 0. Assert rst mid-SHARED -> all outputs 0 on next edge.
- Ports 0,1,2 req_read with ids 3,5,7 in cycle 0 -> grant 0111 at cycle 1, holder_count 3, writer_active 0.
- Port 3 req_write id 2, port 0 req_read id 4, both in cycle 0 -> grant 1000 at cycle 1. Release port 3 at cycle 4 -> grant 0001 at cycle 5.
- SHARED with ports 0,1 (ids 1,2); port 2 req_write id 3; port 3 req_read id 6 -> port 3 not granted. Release ports 0,1 in the same cycle N -> grant 0100 at N+1. Port 2 release at M -> grant 1000 at M+1.
- Wrap-around: port 0 req_write id 14, port 1 req_write id 1, same cycle -> port 0 first (0001). Port 1 granted the cycle after port 0's release.
- Equal ids 9 on ports 1,2 writes -> port 1 first. Release pulse on non-holder port 3 -> no output change. Port 1 release with req still high -> port 2 granted at N+1, port 1 re-granted only after port 2 releases.

Source files
------------

// File: rtl/ordered_rw_arbiter.sv
// Issue-order reader/writer arbiter guarding a shared condition register.
// Readers may hold the lock together; a writer holds it alone. Age comes from
// each requester's issue id compared modulo 2^ID_WIDTH, lower port breaks ties.
module ordered_rw_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   req_issue_id,
  input  logic [NUM_PORTS-1:0]                 release_lock,
  output logic [NUM_PORTS-1:0]                 grant,
  output logic                                 lock_busy,
  output logic                                 writer_active,
  output logic [$clog2(NUM_PORTS+1)-1:0]       holder_count
);

  localparam int CNT_W = $clog2(NUM_PORTS+1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHARED,
    ST_EXCL
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 wa_q, wa_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] held;
  logic [NUM_PORTS-1:0] pend;
  logic [NUM_PORTS-1:0] pend_w;
  logic [NUM_PORTS-1:0] pend_r;
  logic [NUM_PORTS-1:0] oldest;
  logic [NUM_PORTS-1:0] p_onehot;
  logic [NUM_PORTS-1:0] rd_ok;
  logic                 found;

  // Port a is ahead of port b: older by wrap-around id, or same id and lower index.
  function automatic logic is_before(input logic [ID_WIDTH-1:0] id_a,
                                     input logic [ID_WIDTH-1:0] id_b,
                                     input int port_a,
                                     input int port_b);
    logic [ID_WIDTH-1:0] diff;
    diff = id_a - id_b;
    return diff[ID_WIDTH-1] | ((id_a == id_b) & (port_a < port_b));
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PORTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Arbitration: apply releases, find the oldest pending port and eligible readers, pick next holders.
  always_comb begin
    held   = grant_q & ~release_lock;
    pend   = (req_read | req_write) & ~grant_q & ~release_lock;
    pend_w = pend & req_write;
    pend_r = pend & ~req_write;

    oldest = pend;
    rd_ok  = pend_r;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (j != i && pend[j] && is_before(req_issue_id[j], req_issue_id[i], j, i))
          oldest[i] = 1'b0;
        if (pend_w[j] && !is_before(req_issue_id[i], req_issue_id[j], i, j))
          rd_ok[i] = 1'b0;
      end
    end

    // Guard against several "oldest" candidates if ids span more than half the id space.
    p_onehot = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oldest[i] && !found) begin
        p_onehot[i] = 1'b1;
        found       = 1'b1;
      end
    end

    grant_d = held;
    state_d = state_q;
    if (held == '0) begin
      if (!found) begin
        state_d = ST_IDLE;
      end else if ((p_onehot & req_write) != '0) begin
        grant_d = p_onehot;
        state_d = ST_EXCL;
      end else begin
        grant_d = rd_ok;
        state_d = ST_SHARED;
      end
    end else if (state_q == ST_SHARED) begin
      grant_d = held | rd_ok;
    end

    busy_d = (grant_d != '0);
    wa_d   = (state_d == ST_EXCL);
    cnt_d  = popcount(grant_d);
  end

  // State and registered outputs; reset drops every holder immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      wa_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      wa_q    <= wa_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant         = grant_q;
  assign lock_busy     = busy_q;
  assign writer_active = wa_q;
  assign holder_count  = cnt_q;

  a_single_writer: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_EXCL) |-> (popcount(grant_q) == CNT_W'(1)));
  a_count_match: assert property (@(posedge clk) disable iff (rst)
    cnt_q == popcount(grant_q));
  a_busy_match: assert property (@(posedge clk) disable iff (rst)
    busy_q == (cnt_q != '0));
  a_wa_match: assert property (@(posedge clk) disable iff (rst)
    wa_q == (state_q == ST_EXCL));

endmodule

// File: tb/tb_ordered_rw_arbiter.sv
// Bench for ordered_rw_arbiter: directed scenarios followed by random episodes,
// all checked through an expected-response queue against a reference model.
module tb_ordered_rw_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int CW = $clog2(N+1);

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_read, req_write, release_lock, grant;
  logic [N-1:0][W-1:0] req_issue_id;
  logic                lock_busy, writer_active;
  logic [CW-1:0]       holder_count;

  ordered_rw_arbiter #(.NUM_PORTS(N), .ID_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_issue_id (req_issue_id),
    .release_lock (release_lock),
    .grant        (grant),
    .lock_busy    (lock_busy),
    .writer_active(writer_active),
    .holder_count (holder_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  g;
    logic          busy;
    logic          wa;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Driven stimulus, persistent between ticks (release is a pulse).
  logic                drv_rst = 1'b1;
  logic [N-1:0]        drv_rd  = '0;
  logic [N-1:0]        drv_wr  = '0;
  logic [N-1:0]        drv_rel = '0;
  logic [N-1:0][W-1:0] drv_id  = '0;

  // Reference model: current holder set and mode (0 idle, 1 readers, 2 writer).
  logic [N-1:0] m_grant = '0;
  int           m_mode  = 0;

  function automatic bit ahead(input int a, input int b);
    int ia, ib, d;
    ia = int'(drv_id[a]);
    ib = int'(drv_id[b]);
    d  = (((ia - ib) % (1 << W)) + (1 << W)) % (1 << W);
    return (d >= (1 << (W-1))) || (ia == ib && a < b);
  endfunction

  task automatic model_step();
    int           plist[$];
    int           k, fw;
    bit           got;
    logic [N-1:0] holders, ng;
    if (drv_rst) begin
      m_grant = '0;
      m_mode  = 0;
    end else begin
      holders = m_grant & ~drv_rel;
      for (int i = 0; i < N; i++) begin
        if ((drv_rd[i] || drv_wr[i]) && !m_grant[i] && !drv_rel[i]) begin
          k = 0;
          while (k < plist.size() && ahead(plist[k], i)) k++;
          plist.insert(k, i);
        end
      end
      fw  = plist.size();
      got = 1'b0;
      for (int q = 0; q < plist.size(); q++)
        if (!got && drv_wr[plist[q]]) begin fw = q; got = 1'b1; end
      ng = holders;
      if (holders == '0) begin
        if (plist.size() == 0) begin
          m_mode = 0;
        end else if (drv_wr[plist[0]]) begin
          ng[plist[0]] = 1'b1;
          m_mode = 2;
        end else begin
          for (int q = 0; q < fw; q++) ng[plist[q]] = 1'b1;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        for (int q = 0; q < fw; q++) ng[plist[q]] = 1'b1;
      end
      m_grant = ng;
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    rst          = drv_rst;
    req_read     = drv_rd;
    req_write    = drv_wr;
    req_issue_id = drv_id;
    release_lock = drv_rel;
    model_step();
    e.g    = m_grant;
    e.busy = (m_grant != '0);
    e.wa   = (m_mode == 2);
    e.cnt  = CW'($countones(m_grant));
    expq.push_back(e);
    drv_rel = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: each clock the DUT presents one output set; compare it with the queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("grant", 32'(grant), 32'(e.g));
      chk("lock_busy", 32'(lock_busy), 32'(e.busy));
      chk("writer_active", 32'(writer_active), 32'(e.wa));
      chk("holder_count", 32'(holder_count), 32'(e.cnt));
    end
  end

  task automatic clear_all();
    drv_rd = '0; drv_wr = '0; drv_rel = m_grant;
    tick();
    tick();
  endtask

  task automatic random_cycle(input int base);
    for (int i = 0; i < N; i++) begin
      if (m_grant[i]) begin
        if ($urandom_range(0, 99) < 25) begin
          drv_rel[i] = 1'b1;
          if ($urandom_range(0, 99) < 60) begin drv_rd[i] = 1'b0; drv_wr[i] = 1'b0; end
        end else if ($urandom_range(0, 99) < 10) begin
          drv_rd[i] = 1'b0; drv_wr[i] = 1'b0;
        end
      end else if (drv_rd[i] || drv_wr[i]) begin
        if ($urandom_range(0, 99) < 5) begin
          drv_rd[i] = 1'b0; drv_wr[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 3) begin
          drv_rel[i] = 1'b1;
        end
      end else if ($urandom_range(0, 99) < 30) begin
        drv_id[i] = W'((base + int'($urandom_range(0, 3))) % (1 << W));
        case ($urandom_range(0, 3))
          0, 1:    begin drv_rd[i] = 1'b1; drv_wr[i] = 1'b0; end
          2:       begin drv_rd[i] = 1'b0; drv_wr[i] = 1'b1; end
          default: begin drv_rd[i] = 1'b1; drv_wr[i] = 1'b1; end
        endcase
      end else if ($urandom_range(0, 99) < 3) begin
        drv_rel[i] = 1'b1;
      end
    end
    drv_rst = ($urandom_range(0, 199) == 0);
    tick();
    drv_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_read = '0; req_write = '0; req_issue_id = '0; release_lock = '0;

    // Reset then idle.
    drv_rst = 1'b1; ticks(2);
    drv_rst = 1'b0; ticks(5);

    // Three readers share the lock.
    drv_id = {4'd0, 4'd7, 4'd5, 4'd3}; drv_rd = 4'b0111;
    ticks(3);
    clear_all();

    // Older writer beats younger reader; reader follows the writer's release.
    drv_id = {4'd2, 4'd0, 4'd0, 4'd4}; drv_rd = 4'b0001; drv_wr = 4'b1000;
    ticks(4);
    drv_wr = '0; drv_rel = 4'b1000; tick();
    ticks(2);
    clear_all();

    // Writer blocks a younger reader; simultaneous release hands off to the writer.
    drv_id = {4'd6, 4'd3, 4'd2, 4'd1}; drv_rd = 4'b0011;
    ticks(2);
    drv_wr = 4'b0100; drv_rd = 4'b1011;
    ticks(3);
    drv_rd = 4'b1000; drv_rel = 4'b0011; tick();
    ticks(2);
    drv_wr = '0; drv_rel = 4'b0100; tick();
    ticks(2);
    // Reset while readers share the lock.
    drv_rd = 4'b1011; ticks(2);
    drv_rst = 1'b1; tick();
    drv_rst = 1'b0; drv_rd = '0; drv_wr = '0; ticks(2);

    // Wrap-around ordering between two writers.
    drv_id = {4'd0, 4'd0, 4'd1, 4'd14}; drv_wr = 4'b0011;
    ticks(3);
    drv_wr = 4'b0010; drv_rel = 4'b0001; tick();
    ticks(2);
    clear_all();

    // Equal ids, spurious release, re-arbitration after release with request kept.
    drv_id = {4'd0, 4'd9, 4'd9, 4'd0}; drv_wr = 4'b0110;
    ticks(2);
    drv_rel = 4'b1000; tick();
    drv_rel = 4'b0010; tick();
    ticks(3);
    drv_rel = 4'b0100; tick();
    ticks(2);
    clear_all();

    // Random episodes; ids stay inside a narrow window per episode so age is a total order.
    for (int ep = 0; ep < 30; ep++) begin
      int base;
      base = int'($urandom_range(0, 15));
      for (int c = 0; c < 40; c++) random_cycle(base);
      clear_all();
    end

    ticks(3);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
